// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cam_pkg
// Brief   : Shared types and constants for the camera capture front-end.
// Rev     : 1.0
// ============================================================================
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_VS   = 3'd1,
        ST_WAIT_LINE = 3'd2,
        ST_BYTE_HI   = 3'd3,
        ST_BYTE_LO   = 3'd4,
        ST_DONE      = 3'd5
    } cam_state_t;

    localparam int c_R_MSB = 11;
    localparam int c_R_LSB = 8;
    localparam int c_G_MSB = 7;
    localparam int c_G_LSB = 4;
    localparam int c_B_MSB = 3;
    localparam int c_B_LSB = 0;

    localparam int c_DEF_WIDTH  = 160;
    localparam int c_DEF_HEIGHT = 120;

    // First byte carries R in its low nibble, second byte carries {G,B}.
    function automatic logic [11:0] rgb444_pack(input logic [3:0] r, input logic [7:0] gb);
        logic [11:0] p;
        p = '0;
        p[c_R_MSB:c_R_LSB] = r;
        p[c_G_MSB:c_G_LSB] = gb[7:4];
        p[c_B_MSB:c_B_LSB] = gb[3:0];
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_pixel_assembler_if.sv
`default_nettype none
// ============================================================================
// Module  : cam_pixel_assembler_if
// Brief   : Assembled pixel stream with coordinates and frame/line markers.
// Rev     : 1.0
// ============================================================================
interface cam_pixel_assembler_if #(
    parameter int XW = 8,
    parameter int YW = 7
);
    logic          px_valid;
    logic [11:0]   px_data;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic          frame_start;
    logic          line_end;
    logic          frame_end;

    modport master (
        output px_valid, px_data, px_x, px_y, frame_start, line_end, frame_end
    );

    modport slave (
        input  px_valid, px_data, px_x, px_y, frame_start, line_end, frame_end
    );
endinterface
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : cam_sync_edge
// Brief   : Registers VSYNC/HREF/enable and produces edge strobes.
// Rev     : 1.0
// ============================================================================
module cam_sync_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_vsync,
    input  wire logic i_href,
    input  wire logic i_enable,
    output logic      o_vs_rise,
    output logic      o_href_fall,
    output logic      o_en_rise
);
    logic r_vsync;
    logic r_href;
    logic r_enable;
    logic r_en_low_seen;

    // An enable held high across reset must go low once before it can arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync       <= 1'b0;
            r_href        <= 1'b0;
            r_enable      <= 1'b0;
            r_en_low_seen <= 1'b0;
        end else begin
            r_vsync       <= i_vsync;
            r_href        <= i_href;
            r_enable      <= i_enable;
            r_en_low_seen <= r_en_low_seen | ~i_enable;
        end
    end

    assign o_vs_rise   = i_vsync & ~r_vsync;
    assign o_href_fall = ~i_href & r_href;
    assign o_en_rise   = i_enable & ~r_enable & r_en_low_seen;

endmodule
`default_nettype wire

// File: rtl/cam_pixel_assembler.sv
`default_nettype none
// ============================================================================
// Module  : cam_pixel_assembler
// Brief   : Frames the camera byte stream and assembles RGB444 pixels.
// Rev     : 1.0
// ============================================================================
module cam_pixel_assembler
    import cam_pkg::*;
#(
    parameter int WIDTH  = c_DEF_WIDTH,
    parameter int HEIGHT = c_DEF_HEIGHT,
    parameter int XW     = 8,
    parameter int YW     = 7
) (
    input  wire logic            CAM_pclk,
    input  wire logic            CAM_reset,
    input  wire logic            enable,
    input  wire logic            CAM_vsync,
    input  wire logic            CAM_href,
    input  wire logic [7:0]      CAM_px_data,
    cam_pixel_assembler_if.master px,
    output logic                 busy,
    output logic                 done,
    output logic                 len_err
);
    // One extra bit lets the counters hold WIDTH/HEIGHT when saturated.
    localparam logic [XW:0] c_W = (XW+1)'(WIDTH);
    localparam logic [YW:0] c_H = (YW+1)'(HEIGHT);

    logic w_vs_rise;
    logic w_href_fall;
    logic w_en_rise;

    cam_sync_edge u_sync_edge (
        .clk         (CAM_pclk),
        .rst         (CAM_reset),
        .i_vsync     (CAM_vsync),
        .i_href      (CAM_href),
        .i_enable    (enable),
        .o_vs_rise   (w_vs_rise),
        .o_href_fall (w_href_fall),
        .o_en_rise   (w_en_rise)
    );

    cam_state_t    r_state;
    logic [XW:0]   r_x;
    logic [YW:0]   r_y;
    logic [3:0]    r_red;
    logic          r_px_valid;
    logic [11:0]   r_px_data;
    logic [XW-1:0] r_px_x;
    logic [YW-1:0] r_px_y;
    logic          r_frame_start;
    logic          r_line_end;
    logic          r_frame_end;
    logic          r_busy;
    logic          r_done;
    logic          r_len_err;

    logic [XW:0]   w_x_inc;
    logic [YW:0]   w_y_inc;

    assign w_x_inc = (r_x == c_W) ? r_x : r_x + 1'b1;
    assign w_y_inc = (r_y == c_H) ? r_y : r_y + 1'b1;

    always_ff @(posedge CAM_pclk or posedge CAM_reset) begin
        if (CAM_reset) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_red         <= '0;
            r_px_valid    <= 1'b0;
            r_px_data     <= '0;
            r_px_x        <= '0;
            r_px_y        <= '0;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_end   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_len_err     <= 1'b0;
        end else begin
            r_px_valid    <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_end   <= 1'b0;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_en_rise) begin
                        r_len_err <= 1'b0;
                        r_x       <= '0;
                        r_y       <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_state   <= ST_WAIT_VS;
                    end
                end

                ST_WAIT_VS: begin
                    if (w_vs_rise) r_state <= ST_WAIT_LINE;
                end

                ST_WAIT_LINE: begin
                    if (w_vs_rise && (r_y != '0)) begin
                        r_frame_end <= 1'b1;
                        if (r_y != c_H) r_len_err <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (CAM_href && !CAM_vsync) begin
                        r_red <= CAM_px_data[3:0];
                        if (r_y == '0) r_frame_start <= 1'b1;
                        r_state <= ST_BYTE_LO;
                    end
                end

                ST_BYTE_HI, ST_BYTE_LO: begin
                    if (w_vs_rise || w_href_fall) begin
                        // Line close; a VSYNC edge also closes the frame this cycle.
                        if ((r_state == ST_BYTE_LO) || (r_x != c_W)) r_len_err <= 1'b1;
                        if (r_y < c_H) r_line_end <= 1'b1;
                        r_y <= w_y_inc;
                        r_x <= '0;
                        if (w_vs_rise) begin
                            r_frame_end <= 1'b1;
                            if (w_y_inc != c_H) r_len_err <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT_LINE;
                        end
                    end else if (r_state == ST_BYTE_HI) begin
                        r_red   <= CAM_px_data[3:0];
                        r_state <= ST_BYTE_LO;
                    end else begin
                        if ((r_x < c_W) && (r_y < c_H)) begin
                            r_px_valid <= 1'b1;
                            r_px_data  <= rgb444_pack(r_red, CAM_px_data);
                            r_px_x     <= r_x[XW-1:0];
                            r_px_y     <= r_y[YW-1:0];
                        end else begin
                            r_len_err <= 1'b1;
                        end
                        r_x     <= w_x_inc;
                        r_state <= ST_BYTE_HI;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign px.px_valid    = r_px_valid;
    assign px.px_data     = r_px_data;
    assign px.px_x        = r_px_x;
    assign px.px_y        = r_px_y;
    assign px.frame_start = r_frame_start;
    assign px.line_end    = r_line_end;
    assign px.frame_end   = r_frame_end;
    assign busy           = r_busy;
    assign done           = r_done;
    assign len_err        = r_len_err;

endmodule
`default_nettype wire
